remote_comm: RTL and testbench

Host-side command master for the quadcopter link. It serialises one 8-bit command plus 16-bit data word onto a UART line as three bytes and captures the single-byte response returned by the flight controller. It sits in the bench and in the ground-station design opposite the flight controller's UART command receiver.

---
 rtl/remote_comm_pkg.sv | 29 ++
 rtl/remote_comm_if.sv | 23 ++
 rtl/remote_comm_uart.sv | 127 ++++++++++++
 rtl/remote_comm.sv | 103 ++++++++++
 tb/tb_remote_comm.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/remote_comm_pkg.sv
// Shared definitions for the host command link and the quadcopter-side receiver.
// Holds the command opcodes, the acknowledge byte, default baud divisor and the transmit sequencer states.
package remote_comm_pkg;

  localparam int BAUD_DIV_DFLT = 2604;
  localparam int BAUD_W        = 12;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] SET_CAL   = 8'h06;
  localparam logic [7:0] SET_EMGL  = 8'h07;
  localparam logic [7:0] SET_MOFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    MID  = 2'd2,
    LOW  = 2'd3
  } tx_seq_t;

  // 8N1 frame in shift order: start bit in bit 0, stop bit in bit 9.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Host-side command/response handshake bundle for remote_comm.
// master = host logic issuing commands, slave = the remote_comm block.
interface remote_comm_if;

  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  modport master (
    output cmd, data, send_cmd, clr_resp_rdy,
    input  cmd_sent, resp, resp_rdy
  );

  modport slave (
    input  cmd, data, send_cmd, clr_resp_rdy,
    output cmd_sent, resp, resp_rdy
  );

endinterface

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART: one byte per i_trmt (10*BAUD_DIV clocks, tx_done pulses after the stop bit),
// receiver loads o_rx_data and sets o_rdy at the stop-bit sample; no backpressure, trmt while busy is dropped.
module remote_comm_uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_trmt,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_done,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_rdy,
  output logic [7:0] o_rx_data,
  input  logic       i_clr_rdy
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);

  logic              r_tx_busy;
  logic [BAUD_W-1:0] r_tx_baud;
  logic [3:0]        r_tx_bit;
  logic [9:0]        r_tx_shft;
  logic              r_tx_done;
  logic              w_tx_tick;

  assign w_tx_tick = r_tx_busy && (r_tx_baud == BAUD_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_busy <= 1'b0;
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
      r_tx_shft <= '1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (i_trmt) begin
          r_tx_busy <= 1'b1;
          r_tx_baud <= '0;
          r_tx_bit  <= '0;
          r_tx_shft <= frame_of(i_tx_data);
        end
      end else if (w_tx_tick) begin
        r_tx_baud <= '0;
        r_tx_shft <= {1'b1, r_tx_shft[9:1]};
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_baud <= r_tx_baud + 1'b1;
      end
    end
  end

  assign o_tx      = r_tx_shft[0];
  assign o_tx_done = r_tx_done;

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  logic              r_rx_busy;
  logic [BAUD_W-1:0] r_rx_baud;
  logic [3:0]        r_rx_bit;
  logic [7:0]        r_rx_shft;
  logic [7:0]        r_rx_data;
  logic              r_rdy;
  logic              w_rx_start;
  logic              w_rx_tick;
  logic              w_rx_stop;

  assign w_rx_start = !r_rx_busy && r_rx_prev && !r_rx_sync;
  assign w_rx_tick  = r_rx_busy && (r_rx_baud == '0);
  assign w_rx_stop  = w_rx_tick && (r_rx_bit == 4'd9);

  // Sample 0 is the start-bit centre, samples 1..8 are data, sample 9 is the stop bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_baud <= '0;
      r_rx_bit  <= '0;
      r_rx_shft <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (w_rx_start) begin
        r_rx_busy <= 1'b1;
        r_rx_baud <= HALF_LAST;
        r_rx_bit  <= '0;
      end else if (w_rx_tick) begin
        r_rx_baud <= BAUD_LAST;
        r_rx_bit  <= r_rx_bit + 4'd1;
        if (r_rx_bit >= 4'd1 && r_rx_bit <= 4'd8) begin
          r_rx_shft <= {r_rx_sync, r_rx_shft[7:1]};
        end
        if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_data <= r_rx_shft;
        end
      end else if (r_rx_busy) begin
        r_rx_baud <= r_rx_baud - 1'b1;
      end
      if (w_rx_stop) begin
        r_rdy <= 1'b1;
      end else if (i_clr_rdy || w_rx_start) begin
        r_rdy <= 1'b0;
      end
    end
  end

  assign o_rdy     = r_rdy;
  assign o_rx_data = r_rx_data;

endmodule

// File: rtl/remote_comm.sv
// Host command master: sends cmd, data[15:8], data[7:0] as three 8N1 bytes (~30*BAUD_DIV+3 clocks),
// sticky cmd_sent on completion; send_cmd outside IDLE is dropped; response byte captured by the UART.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  remote_comm_if.slave  host,
  output logic          o_tx,
  input  logic          i_rx
);

  tx_seq_t     r_state;
  tx_seq_t     w_state_nxt;
  logic [15:0] r_data;
  logic        r_cmd_sent;

  logic        w_trmt;
  logic [7:0]  w_tx_data;
  logic        w_tx_done;
  logic        w_latch;
  logic        w_set_sent;
  logic        w_rdy;
  logic [7:0]  w_rx_data;

  always_comb begin
    w_state_nxt = r_state;
    w_trmt      = 1'b0;
    w_tx_data   = host.cmd;
    w_latch     = 1'b0;
    w_set_sent  = 1'b0;
    case (r_state)
      IDLE: begin
        if (host.send_cmd) begin
          w_latch     = 1'b1;
          w_trmt      = 1'b1;
          w_tx_data   = host.cmd;
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_tx_done) begin
          w_trmt      = 1'b1;
          w_tx_data   = r_data[15:8];
          w_state_nxt = MID;
        end
      end
      MID: begin
        if (w_tx_done) begin
          w_trmt      = 1'b1;
          w_tx_data   = r_data[7:0];
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        if (w_tx_done) begin
          w_set_sent  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The cmd byte goes straight from the input; only data needs holding across the later bytes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_cmd_sent <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_data     <= host.data;
        r_cmd_sent <= 1'b0;
      end else if (w_set_sent) begin
        r_cmd_sent <= 1'b1;
      end
    end
  end

  remote_comm_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_trmt    (w_trmt),
    .i_tx_data (w_tx_data),
    .o_tx_done (w_tx_done),
    .o_tx      (o_tx),
    .i_rx      (i_rx),
    .o_rdy     (w_rdy),
    .o_rx_data (w_rx_data),
    .i_clr_rdy (host.clr_resp_rdy)
  );

  assign host.cmd_sent = r_cmd_sent;
  assign host.resp     = w_rx_data;
  assign host.resp_rdy = w_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: TX byte decoder, RX byte driver and a responding quad model.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] q_byte[$];
  int         q_cyc[$];
  logic       q_stop[$];

  remote_comm_if u_if();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .host    (u_if.slave),
    .o_tx    (tx),
    .i_rx    (rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decodes every byte on TX by sampling bit centres; records byte, start cycle and stop-bit level.
  initial begin : tx_dec
    logic prev;
    logic [7:0] b;
    int c0;
    prev = 1'b1;
    b = '0;
    forever begin
      @(posedge clk); #1;
      if (prev === 1'b1 && tx === 1'b0) begin
        c0 = cyc;
        repeat (BD/2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (BD) @(posedge clk);
        #1;
        q_stop.push_back(tx);
        q_byte.push_back(b);
        q_cyc.push_back(c0);
        prev = tx;
      end else begin
        prev = tx;
      end
    end
  end

  task automatic clear_q();
    q_byte.delete();
    q_cyc.delete();
    q_stop.delete();
  endtask

  task automatic host_send(input logic [7:0] c, input logic [15:0] d);
    @(posedge clk); #1;
    u_if.cmd = c;
    u_if.data = d;
    u_if.send_cmd = 1'b1;
    @(posedge clk); #1;
    u_if.send_cmd = 1'b0;
    u_if.cmd = 8'hEE;
    u_if.data = 16'hDEAD;
  endtask

  task automatic rx_send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sent(input string tag, output int at);
    int k;
    k = 0;
    while (u_if.cmd_sent !== 1'b1 && k < 40*BD) begin
      @(posedge clk); #1;
      k++;
    end
    at = cyc;
    chk(tag, u_if.cmd_sent, 1'b1);
  endtask

  task automatic wait_rdy(input string tag);
    int k;
    k = 0;
    while (u_if.resp_rdy !== 1'b1 && k < 20*BD) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, u_if.resp_rdy, 1'b1);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k;
    k = 0;
    while (q_byte.size() < n && k < 20*BD) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 32'(q_byte.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int sent_at);
    int lat;
    chk({tag, "_cnt"}, q_byte.size(), 3);
    if (q_byte.size() >= 3) begin
      chk({tag, "_b0"}, q_byte[0], b0);
      chk({tag, "_b1"}, q_byte[1], b1);
      chk({tag, "_b2"}, q_byte[2], b2);
      chk({tag, "_stop"}, {q_stop[0], q_stop[1], q_stop[2]}, 3'b111);
      chk({tag, "_gap01"}, q_cyc[1] - q_cyc[0], 10*BD + 1);
      chk({tag, "_gap12"}, q_cyc[2] - q_cyc[1], 10*BD + 1);
      lat = sent_at - q_cyc[2];
      chk({tag, "_sent_lat"}, 32'(lat >= 10*BD && lat <= 10*BD + 2), 1);
    end
  endtask

  initial begin : main
    int t;
    u_if.cmd = '0;
    u_if.data = '0;
    u_if.send_cmd = 1'b0;
    u_if.clr_resp_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_sent", u_if.cmd_sent, 1'b0);
    chk("rst_rdy", u_if.resp_rdy, 1'b0);
    chk("rst_resp", u_if.resp, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic three-byte command
    clear_q();
    host_send(SET_PTCH, 16'h0100);
    chk("tx_start_low", tx, 1'b0);
    chk("sent_low_after_strobe", u_if.cmd_sent, 1'b0);
    wait_sent("sent1", t);
    check_frame("f1", 8'h02, 8'h01, 8'h00, t);

    // Strobe during byte 2 is ignored
    clear_q();
    host_send(SET_PTCH, 16'h0100);
    wait_bytes("wb2", 1);
    repeat (BD) @(posedge clk);
    #1;
    host_send(SET_EMGL, 16'h1234);
    wait_sent("sent2", t);
    check_frame("f2", 8'h02, 8'h01, 8'h00, t);
    repeat (20*BD) @(posedge clk);
    #1;
    chk("no_extra_frame", q_byte.size(), 3);
    clear_q();
    host_send(SET_EMGL, 16'h1234);
    wait_sent("sent3", t);
    check_frame("f3", 8'h07, 8'h12, 8'h34, t);

    // Response capture and clear
    rx_send(POS_ACK);
    wait_rdy("rdy_a5");
    chk("resp_a5", u_if.resp, 8'hA5);
    @(posedge clk); #1;
    u_if.clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    u_if.clr_resp_rdy = 1'b0;
    chk("rdy_cleared", u_if.resp_rdy, 1'b0);
    chk("resp_held", u_if.resp, 8'hA5);

    // Quad model: receive SET_CAL, reply with POS_ACK
    clear_q();
    host_send(SET_CAL, 16'h0055);
    wait_sent("sent_cal", t);
    chk("rdy_before_ack", u_if.resp_rdy, 1'b0);
    check_frame("fcal", 8'h06, 8'h00, 8'h55, t);
    rx_send((q_byte.size() >= 3 && q_byte[0] == SET_CAL) ? POS_ACK : 8'h00);
    wait_rdy("rdy_cal");
    chk("resp_cal", u_if.resp, 8'hA5);
    host_send(SET_MOFF, 16'h0000);
    chk("sent_clr_on_strobe", u_if.cmd_sent, 1'b0);
    wait_sent("sent_moff", t);

    // Reset during byte 2
    repeat (BD) @(posedge clk);
    #1;
    clear_q();
    host_send(SET_ROLL, 16'hABCD);
    wait_bytes("wb_rst", 1);
    repeat (BD) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_sent", u_if.cmd_sent, 1'b0);
    chk("midrst_resp", u_if.resp, 8'h00);
    rst_n = 1'b1;
    repeat (12*BD) @(posedge clk);
    #1;
    chk("midrst_tx_idle", tx, 1'b1);
    clear_q();
    host_send(SET_YAW, 16'h0203);
    wait_sent("sent_after_rst", t);
    check_frame("frst", 8'h04, 8'h02, 8'h03, t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
